modulo_display_mux: RTL and testbench
=====================================

// Module: modulo_display_mux
// PURPOSE
//  Time-multiplexed 4-digit 7-segment driver, directly downstream of the status digit encoder.
//  Takes four 4-bit digit codes (one of them the encoder's status digit) and scans them onto a
//  common-anode display: one anode active at a time, hex-decoded segments, per-digit decimal point.
//  Digit codes are snapshotted once per full scan, so a display frame never mixes old and new values.
// PARAMETERS
//  DIV_WIDTH  16     width of refresh prescaler counter
//  DIV_MAX    49999  prescaler terminal count; slot period = DIV_MAX+1 clk cycles (1 kHz at 50 MHz)
// PORTS
//  clk     in   1  system clock, rising edge
//  rst     in   1  asynchronous, active-high reset
//  en      in   1  1 = scan active; 0 = display dark, shadow transparent
//  dig0    in   4  digit code, rightmost position (status digit from encoder)
//  dig1    in   4  digit code, position 1
//  dig2    in   4  digit code, position 2
//  dig3    in   4  digit code, leftmost position
//  dp_in   in   4  decimal-point request per position, active-high, bit i -> digit i
//  dim     in   1  half-brightness request (used only with DISPLAY_DIM_EN)
//  an      out  4  anode select, active-low, one-hot-low while scanning
//  seg     out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp      out  1  decimal point, active-low
// BEHAVIOUR
//  Reset (async, any time incl. mid-scan): cnt=0, sel=0, shadow digits=0, shadow dp=0,
//   an=4'b1111, seg=7'b1111111, dp=1. Outputs leave reset values only via a later clock edge.
//  Prescaler: en=1 -> cnt increments each clk; tick=(cnt==DIV_MAX); on tick cnt wraps to 0.
//  Slot: sel (2 bits) increments on tick, wraps 3->0. en=0 -> cnt and sel held at 0.
//  Snapshot: shadow {dig3..dig0, dp_in} loaded on the clock edge where tick && sel==3
//   (same edge sel wraps to 0); while en=0 shadow loads every clock. No other loads.
//  Output stage registered: an/seg/dp at edge t+1 reflect sel/shadow/cnt values held after edge t.
//   Latency input-to-pin: snapshot edge + 1 clk for digit 0.
//  an = ~(4'b0001 << sel) when en=1; 4'b1111 when en=0.
//  seg: hex decode of shadow[sel]; 0=7'b1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//   5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011,
//   C=1000110, D=0100001, E=0000110, F=0001110. en=0 -> 7'b1111111.
//  dp = ~shadow_dp[sel] when en=1; 1 when en=0.
//  en falling mid-slot: next edge outputs dark, cnt/sel to 0. en rising: scan restarts at
//   digit 0 with shadow loaded on the last en=0 clock.
//  Input changes mid-frame have no visible effect until the next snapshot edge.
//  DIV_MAX must be >= 1; DIV_MAX+1 must fit in DIV_WIDTH bits.
// CONFIGURATION
//  Macro DISPLAY_DIM_EN:
//   defined   -> when dim=1 and en=1, an forced 4'b1111 while cnt > (DIV_MAX>>1); active
//                only in first half of every slot. dim=0 -> normal. seg/dp unaffected.
//   undefined -> dim port present but ignored; an depends only on en and sel.
// TESTING  (DIV_MAX=3 unless stated)
//  1 rst=1 async mid-scan, no clk edge -> an=1111, seg=1111111, dp=1 immediately.
//  2 en=1, dig3..0=4'h3,2,1,0 held -> an cycles 1110,1101,1011,0111 every 4 clk; seg 1000000,
//    1111001,0100100,0110000 aligned with each anode.
//  3 change dig0 0->F while sel=1 -> digit-0 slot shows 1000000 until after sel wraps 3->0;
//    next frame shows 0001110.
//  4 dp_in=4'b0100 -> dp=0 only while an=1011, else 1.
//  5 en 1->0 at sel=2 -> next edge an=1111, seg=1111111; en back to 1 -> first slot an=1110.
//  6 DISPLAY_DIM_EN, DIV_MAX=7, dim=1 -> each anode low for 4 of 8 clk (cnt 0..3, 1-clk lag);
//    without macro -> low all 8 clk.

Source files
------------

// File: rtl/modulo_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : modulo_display_mux
// Description : Time-multiplexed 4-digit common-anode 7-segment scanner with
//               per-frame digit snapshot. Optional macro DISPLAY_DIM_EN adds
//               half-brightness dimming driven by the dim input.
// Revision    : 1.0 - initial release
// ============================================================================
module modulo_display_mux #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_MAX   = 49999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dp_in,
  input  logic       dim,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [DIV_WIDTH-1:0] C_DIV_MAX = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [1:0]           r_sel;
  logic [3:0][3:0]      r_shadow_dig;
  logic [3:0]           r_shadow_dp;
  logic [3:0]           r_an;
  logic [6:0]           r_seg;
  logic                 r_dp;

  logic                 w_tick;
  logic                 w_blank;
  logic [3:0]           w_digit;
  logic [6:0]           w_seg;

  assign w_tick  = (r_cnt == C_DIV_MAX);
  assign w_digit = r_shadow_dig[r_sel];

`ifdef DISPLAY_DIM_EN
  localparam logic [DIV_WIDTH-1:0] C_DIV_HALF = DIV_WIDTH'(DIV_MAX >> 1);
  // Anode is lit only in the first half of each slot when dimming.
  assign w_blank = dim && (r_cnt > C_DIV_HALF);
`else
  logic w_unused_dim;
  assign w_unused_dim = dim;
  assign w_blank      = 1'b0;
`endif

  always_comb begin
    w_seg = 7'b1111111;
    case (w_digit)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Prescaler, slot select and frame snapshot; disabled scan keeps shadow transparent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_shadow_dig <= '0;
      r_shadow_dp  <= 4'b0000;
    end else if (!en) begin
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_shadow_dig <= {dig3, dig2, dig1, dig0};
      r_shadow_dp  <= dp_in;
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        r_sel <= r_sel + 2'd1;
        if (r_sel == 2'd3) begin
          r_shadow_dig <= {dig3, dig2, dig1, dig0};
          r_shadow_dp  <= dp_in;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (!en) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_blank ? 4'b1111 : ~(4'b0001 << r_sel);
      r_seg <= w_seg;
      r_dp  <= ~r_shadow_dp[r_sel];
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_modulo_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulo_display_mux
// Description : Directed self-checking bench for modulo_display_mux (DIV_MAX=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modulo_display_mux;

  localparam int C_DIV_MAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       dim = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3, dp_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  modulo_display_mux #(
    .DIV_WIDTH(16),
    .DIV_MAX  (C_DIV_MAX)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .dig0 (dig0),
    .dig1 (dig1),
    .dig2 (dig2),
    .dig3 (dig3),
    .dp_in(dp_in),
    .dim  (dim),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digs(input logic [15:0] d);
    {dig3, dig2, dig1, dig0} = d;
  endtask

  // One full frame: 4 slots x 4 clocks; optional input change after edge chg_at.
  task automatic expect_frame(input string tag, input logic [15:0] digs, input logic [3:0] dps,
                              input bit dimmed, input int chg_at,
                              input logic [15:0] chg_digs, input logic [3:0] chg_dp);
    logic [3:0] exp_an;
    logic [3:0] d;
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 4; j++) begin
        step();
        exp_an = ~(4'b0001 << s);
`ifdef DISPLAY_DIM_EN
        if (dimmed && j >= 2) exp_an = 4'b1111;
`endif
        d = digs[4*s +: 4];
        check_val($sformatf("%s_an_s%0d_c%0d", tag, s, j), {28'd0, an}, {28'd0, exp_an});
        check_val($sformatf("%s_seg_s%0d_c%0d", tag, s, j), {25'd0, seg}, {25'd0, seg_of(d)});
        check_val($sformatf("%s_dp_s%0d_c%0d", tag, s, j), {31'd0, dp}, {31'd0, ~dps[s]});
        if (4*s + j == chg_at) begin
          set_digs(chg_digs);
          dp_in = chg_dp;
        end
      end
    end
  endtask

  initial begin
    set_digs(16'h3210);
    dp_in = 4'b0000;
    #2 rst = 1'b1;
    step();
    step();
    check_val("rst_an", {28'd0, an}, 32'hF);
    check_val("rst_seg", {25'd0, seg}, 32'h7F);
    check_val("rst_dp", {31'd0, dp}, 32'h1);

    rst = 1'b0;
    step();
    step();
    check_val("dis_an", {28'd0, an}, 32'hF);
    check_val("dis_seg", {25'd0, seg}, 32'h7F);

    // Frame 1: inputs change at sel=1 but the frame keeps showing the snapshot.
    en = 1'b1;
    expect_frame("f1", 16'h3210, 4'b0000, 1'b0, 5, 16'h3A1F, 4'b0100);
    dim = 1'b1;
    expect_frame("f2", 16'h3A1F, 4'b0100, 1'b1, -1, 16'h0, 4'b0);
    dim = 1'b0;

    // Frame 3: drop en while sel=2.
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 4) check_val("f3_an_s1", {28'd0, an}, 32'hD);
    end
    check_val("f3_an_s2", {28'd0, an}, 32'hB);
    en = 1'b0;
    set_digs(16'h7659);
    step();
    check_val("off_an", {28'd0, an}, 32'hF);
    check_val("off_seg", {25'd0, seg}, 32'h7F);
    check_val("off_dp", {31'd0, dp}, 32'h1);
    step();
    en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      check_val($sformatf("re_an_c%0d", j), {28'd0, an}, 32'hE);
      check_val($sformatf("re_seg_c%0d", j), {25'd0, seg}, {25'd0, seg_of(4'h9)});
      check_val($sformatf("re_dp_c%0d", j), {31'd0, dp}, 32'h1);
    end
    step();
    check_val("re_an_s1", {28'd0, an}, 32'hD);
    check_val("re_seg_s1", {25'd0, seg}, {25'd0, seg_of(4'h5)});

    // Asynchronous reset mid-scan, sampled before any further clock edge.
    step();
    #2 rst = 1'b1;
    #1;
    check_val("arst_an", {28'd0, an}, 32'hF);
    check_val("arst_seg", {25'd0, seg}, 32'h7F);
    check_val("arst_dp", {31'd0, dp}, 32'h1);
    step();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
